// File: rtl/xbar_spi_config_if.sv
// SPI pins plus the committed crossbar select word, bundled for xbar_spi_config.
// The master modport is the SPI master / crossbar side; the slave modport is the config block.
interface xbar_spi_config_if;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic [5:0] cfg;
  logic       cfg_upd;
  logic       err;

  modport master (
    output sclk, cs_n, mosi,
    input  miso, cfg, cfg_upd, err
  );

  modport slave (
    input  sclk, cs_n, mosi,
    output miso, cfg, cfg_upd, err
  );
endinterface

// File: rtl/xbar_spi_config.sv
// SPI-slave (mode 0) configuration register holding the crossbar's 6-bit one-hot select word.
// Define XBAR_CFG_ONEHOT_CHECK_EN to reject writes whose select fields are not one-hot.
module xbar_spi_config #(
  parameter int         FRAME_W   = 8,
  parameter logic [5:0] RESET_CFG = 6'b100100
) (
  input  logic            clk,
  input  logic            rst_n,
  xbar_spi_config_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  localparam int                CNT_W    = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FRAME_W);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == FULL_CNT) ? cnt : cnt + CNT_W'(1);
  endfunction

`ifdef XBAR_CFG_ONEHOT_CHECK_EN
  function automatic logic onehot3(input logic [2:0] f);
    return (f == 3'b100) || (f == 3'b010) || (f == 3'b001);
  endfunction
`endif

  state_t             state, state_nxt;
  logic               sclk_p0, sclk_p1, sclk_p2;
  logic               cs_n_p0, cs_n_p1, cs_n_p2;
  logic               mosi_p0, mosi_p1;
  logic               sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [CNT_W-1:0]   bit_cnt;
  logic               wr_bit;
  logic [5:0]         cfg_sr;
  logic [FRAME_W-1:0] tx_sr;
  logic [5:0]         cfg_q;
  logic               upd_q;
  logic               err_q;
  logic               fields_ok;
  logic               take_bit;

  // Stage p0/p1: two-flop synchronisers; p2: edge-detect history for sclk and cs_n.
  // cs_n history resets low so a master still selected across reset must re-assert cs_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
      cs_n_p0 <= 1'b0;
      cs_n_p1 <= 1'b0;
      cs_n_p2 <= 1'b0;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
    end else begin
      sclk_p0 <= bus.sclk;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      cs_n_p0 <= bus.cs_n;
      cs_n_p1 <= cs_n_p0;
      cs_n_p2 <= cs_n_p1;
      mosi_p0 <= bus.mosi;
      mosi_p1 <= mosi_p0;
    end
  end

  assign sclk_rise = sclk_p1 & ~sclk_p2;
  assign sclk_fall = ~sclk_p1 & sclk_p2;
  assign cs_fall   = ~cs_n_p1 & cs_n_p2;
  assign cs_rise   = cs_n_p1 & ~cs_n_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = SHIFT;
      SHIFT:   if (cs_rise) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A deselect seen in the same cycle as an sclk edge ends the frame; the edge is dropped.
  assign take_bit = (state == SHIFT) && !cs_rise && sclk_rise && (bit_cnt != FULL_CNT);

`ifdef XBAR_CFG_ONEHOT_CHECK_EN
  assign fields_ok = onehot3(cfg_sr[5:3]) & onehot3(cfg_sr[2:0]);
`else
  assign fields_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      cfg_q   <= RESET_CFG;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      case (state)
        IDLE: if (cs_fall) bit_cnt <= '0;
        SHIFT: if (!cs_rise && sclk_rise) bit_cnt <= sat_inc(bit_cnt);
        COMMIT: begin
          // Abort and invalid fields both land here, so err is set once per frame.
          if (bit_cnt != FULL_CNT)  err_q <= 1'b1;
          else if (!wr_bit)         err_q <= 1'b0;
          else if (fields_ok) begin
            cfg_q <= cfg_sr;
            upd_q <= 1'b1;
          end else                  err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Receive/transmit shifters: the reserved bit (second on the wire) is never stored.
  always_ff @(posedge clk) begin
    if (state == IDLE && cs_fall) begin
      wr_bit <= 1'b0;
      cfg_sr <= '0;
      tx_sr  <= {err_q, 1'b0, cfg_q};
    end else if (take_bit) begin
      if (bit_cnt == CNT_W'(0))       wr_bit <= mosi_p1;
      else if (bit_cnt >= CNT_W'(2))  cfg_sr <= {cfg_sr[4:0], mosi_p1};
    end else if (state == SHIFT && !cs_rise && sclk_fall) begin
      tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
    end
  end

  assign bus.miso    = (state == SHIFT) ? tx_sr[FRAME_W-1] : 1'b0;
  assign bus.cfg     = cfg_q;
  assign bus.cfg_upd = upd_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_xbar_spi_config.sv
// Table-driven SPI frame bench for xbar_spi_config with a scoreboard queue of expected frame results.
// Expectations follow XBAR_CFG_ONEHOT_CHECK_EN when the bench is built with it defined.
`timescale 1ns/1ps
module tb_xbar_spi_config;

`ifdef XBAR_CFG_ONEHOT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [15:0] data;   // frame bits, MSB first from bit 15
    int          nbits;
    logic [15:0] rd;     // bits expected on miso, right-aligned
    logic [5:0]  cfg;
    logic        err;
    logic        upd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs [10];
  vec_t exp_q [$];
  logic [5:0] model_cfg;

  always #5 clk = ~clk;

  xbar_spi_config_if bus ();

  xbar_spi_config #(.FRAME_W(8), .RESET_CFG(6'b100100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic [15:0] data, input int nbits, output logic [15:0] rd);
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = data[15-i];
      repeat (4) @(negedge clk);
      bus.sclk = 1'b1;
      rd = {rd[14:0], bus.miso};
      repeat (4) @(negedge clk);
      bus.sclk = 1'b0;
    end
  endtask

  // Runs one frame and watches the 8 clk cycles after deselect for the commit pulse.
  task automatic do_frame(input logic [15:0] data, input int nbits, output logic [15:0] rd,
                          output int upd_cyc, output int upd_cnt, output logic [5:0] cfg_c3);
    bus.cs_n = 1'b0;
    repeat (6) @(negedge clk);
    send_bits(data, nbits, rd);
    repeat (4) @(negedge clk);
    bus.cs_n = 1'b1;
    upd_cyc = 0;
    upd_cnt = 0;
    cfg_c3  = '0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (bus.cfg_upd) begin
        upd_cnt++;
        if (upd_cyc == 0) upd_cyc = c;
      end
      if (c == 3) cfg_c3 = bus.cfg;
    end
    @(negedge clk);
    bus.mosi = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    vec_t        e;
    logic [15:0] rd;
    int          upd_cyc, upd_cnt;
    logic [5:0]  cfg_c3;
    exp_q.push_back(v);
    do_frame(v.data, v.nbits, rd, upd_cyc, upd_cnt, cfg_c3);
    e = exp_q.pop_front();
    check({tag, "_miso"},     rd, e.rd);
    check({tag, "_cfg"},      16'(bus.cfg), 16'(e.cfg));
    check({tag, "_err"},      16'(bus.err), 16'(e.err));
    check({tag, "_upd_cnt"},  16'(upd_cnt), 16'(e.upd));
    check({tag, "_upd_cyc"},  16'(upd_cyc), e.upd ? 16'd4 : 16'd0);
    check({tag, "_cfg_hold"}, 16'(cfg_c3), 16'(model_cfg));
    check({tag, "_miso_idle"}, 16'(bus.miso), 16'd0);
    model_cfg = e.cfg;
  endtask

  initial begin
    logic [15:0] dummy;
    int          upd_seen;
    vec_t        rec;

    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cfg",  16'(bus.cfg), 16'h0024);
    check("rst_err",  16'(bus.err), 16'd0);
    check("rst_miso", 16'(bus.miso), 16'd0);
    check("rst_upd",  16'(bus.cfg_upd), 16'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    vecs[0] = '{16'h8A00, 8, 16'h0024, 6'b001010, 1'b0, 1'b1};
    vecs[1] = '{16'h9900, 8, 16'h000A, CHK ? 6'b001010 : 6'b011001, CHK, !CHK};
    vecs[2] = '{16'h0000, 8, CHK ? 16'h008A : 16'h0019, CHK ? 6'b001010 : 6'b011001, 1'b0, 1'b0};
    vecs[3] = '{16'hA100, 5, CHK ? 16'h0001 : 16'h0003, CHK ? 6'b001010 : 6'b011001, 1'b1, 1'b0};
    vecs[4] = '{16'h0000, 8, CHK ? 16'h008A : 16'h0099, CHK ? 6'b001010 : 6'b011001, 1'b0, 1'b0};
    vecs[5] = '{16'h9400, 8, CHK ? 16'h000A : 16'h0019, 6'b010100, 1'b0, 1'b1};
    vecs[6] = '{16'h0000, 8, 16'h0014, 6'b010100, 1'b0, 1'b0};
    vecs[7] = '{16'hA1C0, 10, 16'h0050, 6'b100001, 1'b0, 1'b1};
    vecs[8] = '{16'h7F00, 8, 16'h0021, 6'b100001, 1'b0, 1'b0};
    vecs[9] = '{16'h0000, 3, 16'h0001, 6'b100001, 1'b1, 1'b0};

    model_cfg = 6'b100100;
    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of a frame, with err set and a non-default cfg.
    bus.cs_n = 1'b0;
    repeat (6) @(negedge clk);
    send_bits(16'hFFFF, 3, dummy);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_cfg",  16'(bus.cfg), 16'h0024);
    check("midrst_err",  16'(bus.err), 16'd0);
    check("midrst_miso", 16'(bus.miso), 16'd0);
    check("midrst_upd",  16'(bus.cfg_upd), 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("postrst_miso_sel", 16'(bus.miso), 16'd0);
    bus.cs_n = 1'b1;
    upd_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (bus.cfg_upd) upd_seen++;
    end
    check("postrst_upd", 16'(upd_seen), 16'd0);
    check("postrst_err", 16'(bus.err), 16'd0);
    check("postrst_cfg", 16'(bus.cfg), 16'h0024);

    model_cfg = 6'b100100;
    rec = '{16'h8A00, 8, 16'h0024, 6'b001010, 1'b0, 1'b1};
    run_vec(rec, "recover");

    check("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
